// File: rtl/event_pulse_pacer.sv
// event_pulse_pacer: turns rising edges of a fast-domain event level into
// paced single-cycle pulses for a fast->slow pulse synchronizer.
//   clk_fast  : fast-domain clock, rising edge
//   rst_n     : asynchronous active-low reset
//   event_in  : event level; every 0->1 transition is one event
//   ds_busy   : downstream synchronizer busy, checked only while idle
//   clr       : synchronous clear of pending count and overflow flag
//   pulse_out : registered one-cycle pulse, high while in FIRE
//   pending   : events accepted but not yet issued (saturating)
//   overflow  : sticky, an event was lost at saturation
//   busy      : FSM not idle or events still pending
module event_pulse_pacer #(
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic             clk_fast,
    input  logic             rst_n,
    input  logic             event_in,
    input  logic             ds_busy,
    input  logic             clr,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, FIRE, GAP} state_t;
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    state_t     state;
    logic [7:0] gap_cnt;
    logic       event_d;
    logic       rise;
    logic       fire_go;
    assign rise    = event_in & ~event_d;
    // Issue decision uses the registered pending value, so a freshly counted
    // event becomes eligible one edge after it was counted.
    assign fire_go = (state == IDLE) && (pending != '0) && !ds_busy;
    assign busy    = (state != IDLE) || (pending != '0);
    // A rise and an issue on the same edge cancel; clr wins over both.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            event_d  <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            event_d <= event_in;
            if (clr) begin
                pending  <= '0;
                overflow <= 1'b0;
            end else if (rise && !fire_go) begin
                if (pending == PEND_MAX)
                    overflow <= 1'b1;
                else
                    pending <= pending + 1'b1;
            end else if (!rise && fire_go) begin
                pending <= pending - 1'b1;
            end
        end
    end
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_cnt   <= 8'd0;
            pulse_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= fire_go ? FIRE : IDLE;
                    pulse_out <= fire_go;
                end
                FIRE: begin
                    state     <= GAP;
                    gap_cnt   <= 8'(GAP_CYCLES);
                    pulse_out <= 1'b0;
                end
                GAP: begin
                    gap_cnt   <= gap_cnt - 8'd1;
                    state     <= (gap_cnt == 8'd1) ? IDLE : GAP;
                    pulse_out <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    pulse_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/event_pulse_pacer.md
EVENT_PULSE_PACER -- requirements
Module: event_pulse_pacer

Interface
REQ-001 Parameter CNT_W, default 4: width of the pending-event counter.
REQ-002 Parameter GAP_CYCLES, default 8: guard cycles after each issued pulse; legal range 1..255.
REQ-003 clk_fast  input  1  fast-domain clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 event_in  input  1  level event source, fast domain; each 0->1 transition is one event.
REQ-006 ds_busy  input  1  downstream synchronizer busy; tie 0 when unused.
REQ-007 clr  input  1  synchronous clear of pending count and overflow flag.
REQ-008 pulse_out  output  1  single-cycle pulse feeding the fast->slow pulse synchronizer's data_in.
REQ-009 pending  output  CNT_W  events accepted but not yet issued.
REQ-010 overflow  output  1  sticky flag: an event was lost at saturation.
REQ-011 busy  output  1  high when state is not IDLE or pending is nonzero.

Function
REQ-012 The block SHALL register event_in into event_d (reset 0); rise = event_in & ~event_d.
REQ-013 A level held high SHALL count as exactly one event.
REQ-014 pending SHALL increment by 1 on the edge where rise is 1, and decrement by 1 on each IDLE->FIRE transition edge.
REQ-015 Rise and decrement on the same edge SHALL leave pending unchanged.
REQ-016 pending SHALL saturate at 2^CNT_W-1.
REQ-017 At saturation, a rise with no same-edge decrement SHALL set overflow; pending SHALL hold.
REQ-018 overflow SHALL stay set until clr or reset.
REQ-019 clr SHALL zero pending and overflow on the next edge and SHALL take priority over a same-edge rise (that event is dropped).
REQ-020 clr SHALL NOT affect FSM state or the gap counter.
REQ-021 FSM states SHALL be IDLE, FIRE and GAP.
REQ-022 IDLE->FIRE SHALL occur when pending != 0 and ds_busy == 0; otherwise the FSM stays in IDLE.
REQ-023 A pending count updated on edge k SHALL be eligible for IDLE->FIRE at edge k+1 at the earliest.
REQ-024 ds_busy SHALL be sampled only in IDLE.
REQ-025 FIRE->GAP SHALL be unconditional after one cycle, loading the gap counter with GAP_CYCLES.
REQ-026 In GAP the gap counter SHALL decrement each cycle; when the counter equals 1, the FSM SHALL go to IDLE.
REQ-027 The FSM SHALL therefore spend exactly GAP_CYCLES cycles in GAP.
REQ-028 pulse_out SHALL be a flop output, high exactly for the single cycle the FSM is in FIRE.
REQ-029 Latency: rise sampled at edge k with the FSM in IDLE and ds_busy low SHALL put pulse_out high after edge k+1; pending reads 1 after edge k and 0 after edge k+1.
REQ-030 Consecutive pulse_out rising edges SHALL be at least GAP_CYCLES+2 cycles apart (10 at default).
REQ-031 Events arriving during FIRE or GAP SHALL be queued in pending, never dropped below saturation.
REQ-032 busy SHALL be combinational from state and pending, glitch-free with respect to clk_fast edges.

Reset
REQ-033 On rst_n low, the block SHALL asynchronously set: state=IDLE, gap counter=0, event_d=0, pending=0, overflow=0, pulse_out=0, busy=0.
REQ-034 Reset asserted mid-FIRE or mid-GAP SHALL abort immediately.
REQ-035 After reset, no pulse SHALL issue for events accepted before the reset.
REQ-036 The first post-reset rise SHALL follow REQ-029 timing.

Verification
REQ-037 Single 0->1 on event_in sampled at edge k -> pending=1 after k; pulse_out=1 for exactly the cycle after k+1; pending=0 after k+1.
REQ-038 Three rises at 2-cycle spacing, defaults -> exactly three one-cycle pulses with rising edges 10 cycles apart; pending peaks at 2 and ends at 0.
REQ-039 event_in held high for 20 cycles -> exactly one pulse; overflow=0.
REQ-040 ds_busy=1 while event_in toggles to give 17 rises -> pending=15, overflow=1, no pulse; then ds_busy=0 -> 15 pulses at 10-cycle spacing, pending=0, overflow still 1.
REQ-041 clr pulsed in GAP with pending=3 -> pending=0 and overflow=0 next cycle, GAP runs to IDLE, no further pulses; clr with a same-edge rise -> pending=0.
REQ-042 rst_n low mid-GAP with pending=5 -> all outputs 0 immediately; after release one rise -> one pulse per REQ-029 timing.
